// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and helpers that derive frame totals.
// Shared by the timing generator and anything that needs to know the raster size.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CNT_W    = 10;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // True when an unsigned counter of the given width can reach value.
  function automatic bit fits_width(input int value, input int width);
    if (value < 0) return 1'b0;
    if (width >= 31) return 1'b1;
    return value < (1 << width);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear to 0 so the synchronized value is deasserted out of reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters gated by a synchronized
// clock-lock flag, with all sync/active/coordinate outputs registered one cycle late.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = DEF_CNT_W
) (
  input  logic             pixel_clk,
  input  logic             resetn,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  localparam logic [31:0] H_ACT_END    = 32'(H_ACTIVE);
  localparam logic [31:0] H_SYNC_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SYNC_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END    = 32'(V_ACTIVE);
  localparam logic [31:0] V_SYNC_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SYNC_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (!fits_width(H_TOTAL - 1, CNT_W)) begin : g_h_width_check
      $error("vga_timing_gen: CNT_W=%0d cannot hold H_TOTAL-1=%0d", CNT_W, H_TOTAL - 1);
    end
    if (!fits_width(V_TOTAL - 1, CNT_W)) begin : g_v_width_check
      $error("vga_timing_gen: CNT_W=%0d cannot hold V_TOTAL-1=%0d", CNT_W, V_TOTAL - 1);
    end
  endgenerate

  logic w_lockS;

  sync_2ff u_lock_sync (
    .i_clk   (pixel_clk),
    .i_rst_n (resetn),
    .i_d     (locked),
    .o_q     (w_lockS)
  );

  logic [CNT_W-1:0] r_hCnt;
  logic [CNT_W-1:0] r_vCnt;
  logic             w_hWrap;
  logic             w_vWrap;

  assign w_hWrap = (r_hCnt == H_LAST);
  assign w_vWrap = (r_vCnt == V_LAST);

  // Counters park at the origin whenever lock is lost, so relock restarts a frame.
  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (!w_lockS) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_hWrap) begin
      r_hCnt <= '0;
      r_vCnt <= w_vWrap ? '0 : r_vCnt + 1'b1;
    end else begin
      r_hCnt <= r_hCnt + 1'b1;
    end
  end

  logic [31:0] w_hWide;
  logic [31:0] w_vWide;
  logic        w_activeNext;
  logic        w_hSyncOn;
  logic        w_vSyncOn;
  logic        w_lineStartNext;
  logic        w_frameStartNext;

  assign w_hWide = 32'(r_hCnt);
  assign w_vWide = 32'(r_vCnt);

  always_comb begin
    w_activeNext     = (w_hWide < H_ACT_END) && (w_vWide < V_ACT_END);
    w_hSyncOn        = (w_hWide >= H_SYNC_START) && (w_hWide < H_SYNC_END);
    w_vSyncOn        = (w_vWide >= V_SYNC_START) && (w_vWide < V_SYNC_END);
    w_lineStartNext  = (r_hCnt == '0);
    w_frameStartNext = (r_hCnt == '0) && (r_vCnt == '0);
  end

  logic             r_hsync;
  logic             r_vsync;
  logic             r_active;
  logic [CNT_W-1:0] r_pixelX;
  logic [CNT_W-1:0] r_pixelY;
  logic             r_lineStart;
  logic             r_frameStart;

  // Decodes are gated by the lock flag seen before the edge, giving the idle pattern while unlocked.
  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) begin
      r_hsync      <= ~HSYNC_POL;
      r_vsync      <= ~VSYNC_POL;
      r_active     <= 1'b0;
      r_pixelX     <= '0;
      r_pixelY     <= '0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else if (!w_lockS) begin
      r_hsync      <= ~HSYNC_POL;
      r_vsync      <= ~VSYNC_POL;
      r_active     <= 1'b0;
      r_pixelX     <= '0;
      r_pixelY     <= '0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_hsync      <= w_hSyncOn ? HSYNC_POL : ~HSYNC_POL;
      r_vsync      <= w_vSyncOn ? VSYNC_POL : ~VSYNC_POL;
      r_active     <= w_activeNext;
      r_pixelX     <= r_hCnt;
      r_pixelY     <= r_vCnt;
      r_lineStart  <= w_lineStartNext;
      r_frameStart <= w_frameStartNext;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign pixel_x     = r_pixelX;
  assign pixel_y     = r_pixelY;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken 32x20 raster so whole frames fit in a short run.
// Stimulus pushes the expected outputs per cycle; a negedge monitor pops and compares.
module tb_vga_timing_gen;

  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int HT = 32;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 3;
  localparam int VB = 3;
  localparam int VT = 20;
  localparam int FT = HT * VT;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          locked = 1'b0;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;

  vga_timing_gen #(
    .H_ACTIVE  (HA),
    .H_FP      (HF),
    .H_SYNC    (HS),
    .H_BP      (HB),
    .V_ACTIVE  (VA),
    .V_FP      (VF),
    .V_SYNC    (VS),
    .V_BP      (VB),
    .HSYNC_POL (1'b0),
    .VSYNC_POL (1'b0),
    .CNT_W     (CW)
  ) dut (
    .pixel_clk   (clk),
    .resetn      (resetn),
    .locked      (locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hs;
    logic          vs;
    logic          act;
    logic          ls;
    logic          fs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    int            k;
    string         tag;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int actCnt      = 0;
  int hsLowCnt    = 0;
  int vsLowCnt    = 0;
  int lsCnt       = 0;
  int fsSeen      = 0;
  int fsCyc0      = 0;
  int fsCyc1      = 0;

  function automatic exp_t idleExp(input string tag);
    exp_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    e.x = '0; e.y = '0; e.k = -1; e.tag = tag;
    return e;
  endfunction

  // Expected outputs for the k-th counted pixel since a frame_start.
  function automatic exp_t expAt(input int k, input string tag);
    exp_t e;
    int x;
    int y;
    x = k % HT;
    y = (k / HT) % VT;
    e.x   = CW'(x);
    e.y   = CW'(y);
    e.act = (x < HA) && (y < VA);
    e.hs  = ((x >= HA + HF) && (x < HA + HF + HS)) ? 1'b0 : 1'b1;
    e.vs  = ((y >= VA + VF) && (y < VA + VF + VS)) ? 1'b0 : 1'b1;
    e.ls  = (x == 0);
    e.fs  = (x == 0) && (y == 0);
    e.k   = k;
    e.tag = tag;
    return e;
  endfunction

  task automatic applyStimulus(input bit idle, input int k, input string tag);
    @(posedge clk);
    #1;
    if (idle) expQ.push_back(idleExp(tag));
    else      expQ.push_back(expAt(k, tag));
  endtask

  task automatic checkOutput(input string name, input int got, input int req);
    testsRun++;
    if (got != req) begin
      testsFailed++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      testsRun++;
      if (hsync !== monE.hs || vsync !== monE.vs || active !== monE.act ||
          pixel_x !== monE.x || pixel_y !== monE.y ||
          line_start !== monE.ls || frame_start !== monE.fs) begin
        testsFailed++;
        $display("[TB] FAIL %s k=%0d got hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b required hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b",
                 monE.tag, monE.k, hsync, vsync, active, pixel_x, pixel_y, line_start, frame_start,
                 monE.hs, monE.vs, monE.act, monE.x, monE.y, monE.ls, monE.fs);
      end
      if (monE.tag == "run" && monE.k >= 0 && monE.k < FT) begin
        actCnt   += int'(active);
        hsLowCnt += int'(!hsync);
        vsLowCnt += int'(!vsync);
        lsCnt    += int'(line_start);
      end
      if (monE.tag == "run" && frame_start) begin
        if (fsSeen == 0) fsCyc0 = cyc;
        else if (fsSeen == 1) fsCyc1 = cyc;
        fsSeen++;
      end
    end
  end

  initial begin
    resetn = 1'b0;
    locked = 1'b0;
    repeat (4) applyStimulus(1'b1, 0, "reset");

    resetn = 1'b1;
    repeat (3) applyStimulus(1'b1, 0, "unlocked");

    // Two synchronizer stages then one output register: frame_start on the third edge.
    locked = 1'b1;
    repeat (2) applyStimulus(1'b1, 0, "sync_wait");
    for (int k = 0; k <= 2 * FT + 5 * HT + 10; k++) applyStimulus(1'b0, k, "run");

    // Lock lost at pixel (10,5): two more counted pixels drain through the synchronizer.
    locked = 1'b0;
    applyStimulus(1'b0, 2 * FT + 5 * HT + 11, "drop");
    applyStimulus(1'b0, 2 * FT + 5 * HT + 12, "drop");
    repeat (6) applyStimulus(1'b1, 0, "drop_idle");

    locked = 1'b1;
    repeat (2) applyStimulus(1'b1, 0, "relock_wait");
    for (int k = 0; k < 3 * HT + 22; k++) applyStimulus(1'b0, k, "relock");

    // Next edge shows pixel (22,3) with hsync asserted; reset lands between edges.
    @(posedge clk);
    #1;
    resetn = 1'b0;
    expQ.push_back(idleExp("async_reset"));
    locked = 1'b0;
    repeat (3) applyStimulus(1'b1, 0, "in_reset");
    resetn = 1'b1;
    repeat (3) applyStimulus(1'b1, 0, "post_reset");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain got=%0d required=0", expQ.size());
    end

    checkOutput("active_cycles_per_frame", actCnt, HA * VA);
    checkOutput("hsync_low_cycles_per_frame", hsLowCnt, HS * VT);
    checkOutput("vsync_low_cycles_per_frame", vsLowCnt, VS * HT);
    checkOutput("line_starts_per_frame", lsCnt, VT);
    checkOutput("frame_start_count", fsSeen, 3);
    checkOutput("frame_start_period", fsCyc1 - fsCyc0, FT);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter HSYNC_POL, default 0, asserted hsync level (0 = active-low).
REQ-010 Parameter VSYNC_POL, default 0, asserted vsync level (0 = active-low).
REQ-011 Parameter CNT_W, default 10, width of counters and coordinates.
REQ-012 Ports: one clock; reset is asynchronous and active-low.
REQ-013 pixel_clk  input  1  pixel clock; all logic rising-edge on it.
REQ-014 resetn  input  1  asynchronous active-low reset.
REQ-015 locked  input  1  clock-generator lock flag; asynchronous to pixel_clk.
REQ-016 hsync  output  1  horizontal sync, polarity per HSYNC_POL.
REQ-017 vsync  output  1  vertical sync, polarity per VSYNC_POL.
REQ-018 active  output  1  high while the pixel is inside the visible area.
REQ-019 pixel_x  output  CNT_W  horizontal coordinate of the current pixel.
REQ-020 pixel_y  output  CNT_W  vertical coordinate of the current pixel.
REQ-021 line_start  output  1  one-cycle pulse on the first pixel of every line.
REQ-022 frame_start  output  1  one-cycle pulse on pixel (0,0) of every frame.

Function
REQ-023 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults give 800 and 525.
REQ-024 locked SHALL pass through a 2-flop synchronizer; lock_s is the synchronized value.
REQ-025 While lock_s=0, h_cnt and v_cnt SHALL hold at 0, and all outputs SHALL stay at their idle (reset) values.
REQ-026 While lock_s=1, h_cnt SHALL increment every cycle and wrap from H_TOTAL-1 to 0. v_cnt SHALL increment only on that wrap and wrap from V_TOTAL-1 to 0.
REQ-027 Outputs SHALL be registered decodes of (h_cnt, v_cnt), with one cycle of latency. Output values at cycle n reflect the counter values at cycle n-1.
REQ-028 active SHALL equal (h<H_ACTIVE)&&(v<V_ACTIVE).
REQ-029 hsync SHALL be asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and deasserted otherwise.
REQ-030 vsync SHALL be asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, and deasserted otherwise. vsync SHALL change only together with the h=0 line boundary.
REQ-031 pixel_x and pixel_y SHALL equal h and v in all states, including blanking. Their range is 0..H_TOTAL-1 and 0..V_TOTAL-1.
REQ-032 line_start SHALL equal (h==0), and frame_start SHALL equal (h==0 && v==0), each gated by lock_s.
REQ-033 A rising edge of lock_s SHALL start counting from (0,0), so the first outputs produced are the frame_start and line_start pulses.
REQ-034 If lock_s falls mid-frame, counters SHALL return to 0 on the next edge, and outputs SHALL go idle one cycle later.
REQ-035 CNT_W SHALL hold H_TOTAL-1 and V_TOTAL-1. The design SHALL issue an elaboration-time error if either does not fit.

Reset
REQ-036 On resetn=0, the synchronizer flops, h_cnt and v_cnt SHALL clear to 0, asynchronously.
REQ-037 Reset values SHALL be: hsync=~HSYNC_POL, vsync=~VSYNC_POL, active=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0.
REQ-038 After resetn is released, counting SHALL begin no earlier than 2 cycles after locked is high.

Structure
REQ-039 Package vga_timing_pkg SHALL hold the default 640x480@60 timing constants and the derived H_TOTAL and V_TOTAL helper functions.
REQ-040 Sub-module sync_2ff SHALL implement the locked synchronizer. It is 1 bit wide, uses asynchronous active-low reset, and has reset value 0.

Verification
REQ-041 Reset, then locked=1 -> frame_start pulses 3 cycles after locked rises, with pixel_x=0, pixel_y=0 and active=1.
REQ-042 Run one full frame -> exactly 800 cycles per line and 525 lines (420000 cycles per frame). active is high for exactly 307200 cycles per frame.
REQ-043 Line check -> hsync is low for pixel_x 656..751 only, so 96 cycles. active falls at pixel_x=640.
REQ-044 Frame check -> vsync is low for pixel_y 490..491 only, so 1600 cycles. The frame_start period is 420000 cycles.
REQ-045 Drop locked at pixel (300,200) -> within 4 cycles all outputs are idle and the counters are 0. Re-assert locked -> a fresh frame_start occurs at (0,0).
REQ-046 Assert resetn=0 mid-line with no clock edge -> outputs take their reset values immediately (asynchronous reset).
